prog_sequencer: RTL

Parametrised program-flow controller for the next-generation core. It replaces the bare PC/LUT pair and the hard-wired `done` compare with a run-control state machine: a req/done handshake, stall support, halt-instruction and end-address termination, a writable branch-target LUT (relative or absolute targets) and a cycle counter. It sits between the control decoder and the instruction ROM and drives the fetch address.

---
 rtl/prog_sequencer.sv | 111 +++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: run-control FSM driving the instruction fetch address.
// Handles req/done handshake, stalls, halt/end termination and a branch LUT.
module prog_sequencer #(
    parameter int D          = 12,
    parameter int L          = 2,
    parameter int C          = 16,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         stall,
    input  logic         halt,
    input  logic         branch_en,
    input  logic         branch_taken,
    input  logic         jump_abs,
    input  logic [L-1:0] lut_sel,
    input  logic         lut_wr_en,
    input  logic [L-1:0] lut_wr_idx,
    input  logic [D-1:0] lut_wr_data,
    output logic [D-1:0] prog_ctr,
    output logic         fetch_en,
    output logic         busy,
    output logic         done,
    output logic [C-1:0] cycle_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int N = 1 << L;

    // An end address outside the PC range can never be reached, so the
    // compare is disabled instead of matching a truncated value.
    localparam bit END_OK = (END_ADDR >= 0) &&
                            (longint'(END_ADDR) < (longint'(1) << D));
    localparam logic [D-1:0] END_PC   = END_OK ? D'(END_ADDR) : '0;
    localparam logic [D-1:0] START_PC = D'(START_ADDR);
    localparam logic [C-1:0] CNT_MAX  = '1;

    logic [1:0]   state;
    logic [D-1:0] lut [N];
    logic [D-1:0] tgt;
    logic [D-1:0] pc_next;
    logic         at_end;

    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);
    assign fetch_en = busy && !stall;
    assign tgt      = lut[lut_sel];
    assign at_end   = END_OK && (prog_ctr == END_PC);

    // Next PC for an unstalled, non-terminating RUN cycle
    always_comb begin
        pc_next = prog_ctr + D'(1);
        if (branch_en && branch_taken) begin
            pc_next = jump_abs ? tgt : prog_ctr + tgt;
        end
    end

    // Run-control state, program counter and saturating cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            prog_ctr  <= '0;
            cycle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state     <= S_RUN;
                        prog_ctr  <= START_PC;
                        cycle_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (cycle_cnt != CNT_MAX) begin
                        cycle_cnt <= cycle_cnt + C'(1);
                    end
                    if (!stall) begin
                        if (halt || at_end) begin
                            state <= S_DONE;
                        end else begin
                            prog_ctr <= pc_next;
                        end
                    end
                end
                S_DONE: begin
                    if (!req) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Branch-target LUT; reads above see the pre-edge contents
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                lut[i] <= '0;
            end
        end else if (lut_wr_en) begin
            lut[lut_wr_idx] <= lut_wr_data;
        end
    end

endmodule
